// File: rtl/crack_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : crack_scheduler
//  Description : ARC4 key-space scheduler. Splits the key space into fixed
//                chunks, hands them to NCORES crack cores over an en/rdy
//                handshake, collects the first hit and aborts the others.
//  Revision    : 1.0 - initial release
// ============================================================================
module crack_scheduler #(
    parameter int NCORES     = 2,
    parameter int KEY_W      = 24,
    parameter int CHUNK_LOG2 = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     rdy,
    output logic                     done,
    output logic                     key_valid,
    output logic [KEY_W-1:0]         key,
    output logic [NCORES-1:0]        core_en,
    output logic [NCORES*KEY_W-1:0]  core_base,
    output logic [NCORES-1:0]        core_abort,
    input  logic [NCORES-1:0]        core_rdy,
    input  logic [NCORES-1:0]        core_hit,
    input  logic [NCORES*KEY_W-1:0]  core_key
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Chunk stride, one bit wider than a key so the carry marks exhaustion.
    localparam logic [KEY_W:0] c_CHUNK = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [KEY_W:0]           r_next_base;
    logic [NCORES-1:0]        r_busy;
    logic [NCORES-1:0]        r_en_d;
    logic [NCORES-1:0]        r_core_en;
    logic [NCORES-1:0]        r_core_abort;
    logic [NCORES*KEY_W-1:0]  r_core_base;
    logic [KEY_W-1:0]         r_key;
    logic                     r_done;
    logic                     r_key_valid;

    logic                     w_idle;
    logic                     w_run;
    logic                     w_start;
    logic [NCORES-1:0]        w_hit_vec;
    logic [NCORES-1:0]        w_hit_sel;
    logic                     w_hit_any;
    logic [KEY_W-1:0]         w_hit_key;
    logic [NCORES-1:0]        w_free_vec;
    logic [NCORES-1:0]        w_free_sel;
    logic                     w_free_any;
    logic                     w_dispatch;
    logic [KEY_W:0]           w_disp_base;
    logic [NCORES-1:0]        w_complete;
    logic                     w_exhausted;

    assign w_idle      = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign w_run       = (r_state == c_ST_RUN);
    assign w_start     = w_idle && en;
    assign w_hit_vec   = core_hit & r_busy & {NCORES{w_run}};
    assign w_free_vec  = core_rdy & ~r_busy;
    // A freshly dispatched core may still show rdy for two cycles before it
    // drops it, so completion is masked during that window.
    assign w_complete  = r_busy & core_rdy & ~r_core_en & ~r_en_d;
    assign w_exhausted = r_next_base[KEY_W] && (r_busy == '0);
    // A start dispatches key 0 straight away, so the first core_en follows
    // the accepting edge by one cycle.
    assign w_disp_base = w_start ? '0 : r_next_base;
    assign w_dispatch  = w_free_any &&
                         (w_start || (w_run && !w_hit_any && !r_next_base[KEY_W]));

    // Lowest-index hitting core and its reported key.
    always_comb begin
        w_hit_sel = '0;
        w_hit_any = 1'b0;
        w_hit_key = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_hit_vec[i] && !w_hit_any) begin
                w_hit_any    = 1'b1;
                w_hit_sel[i] = 1'b1;
                w_hit_key    = core_key[i*KEY_W +: KEY_W];
            end
        end
    end

    // Lowest-index idle, ready core for the next dispatch.
    always_comb begin
        w_free_sel = '0;
        w_free_any = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_free_vec[i] && !w_free_any) begin
                w_free_any    = 1'b1;
                w_free_sel[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a hit wins over everything else in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (en) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_hit_any || w_exhausted) w_state_nxt = c_ST_DONE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode: the scheduler is ready whenever it is not searching.
    always_comb begin
        rdy = w_idle;
    end

    // Datapath: dispatch, completion, hit capture and abort pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_base  <= '0;
            r_busy       <= '0;
            r_en_d       <= '0;
            r_core_en    <= '0;
            r_core_abort <= '0;
            r_core_base  <= '0;
            r_key        <= '0;
            r_done       <= 1'b0;
            r_key_valid  <= 1'b0;
        end else begin
            r_core_en    <= '0;
            r_core_abort <= '0;
            r_en_d       <= r_core_en;
            if (w_start) begin
                r_done      <= 1'b0;
                r_key_valid <= 1'b0;
                r_next_base <= '0;
                r_busy      <= '0;
            end else if (w_run && w_hit_any) begin
                r_key        <= w_hit_key;
                r_key_valid  <= 1'b1;
                r_done       <= 1'b1;
                r_core_abort <= r_busy & ~w_hit_vec;
                r_busy       <= '0;
            end else if (w_run && w_exhausted) begin
                r_done      <= 1'b1;
                r_key_valid <= 1'b0;
            end else if (w_run) begin
                r_busy <= r_busy & ~w_complete;
            end
            if (w_dispatch) begin
                r_core_en   <= w_free_sel;
                r_next_base <= w_disp_base + c_CHUNK;
                if (w_start) begin
                    r_busy <= w_free_sel;
                end else begin
                    r_busy <= (r_busy & ~w_complete) | w_free_sel;
                end
                for (int i = 0; i < NCORES; i++) begin
                    if (w_free_sel[i]) begin
                        r_core_base[i*KEY_W +: KEY_W] <= w_disp_base[KEY_W-1:0];
                    end
                end
            end
        end
    end

    assign done       = r_done;
    assign key_valid  = r_key_valid;
    assign key        = r_key;
    assign core_en    = r_core_en;
    assign core_abort = r_core_abort;
    assign core_base  = r_core_base;

endmodule
`default_nettype wire

// File: tb/tb_crack_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crack_scheduler
//  Description : Directed self-checking bench for crack_scheduler with
//                behavioural crack cores (small and default configuration).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crack_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- small configuration: KEY_W=4, CHUNK_LOG2=2 ----------
    logic       s_en, s_rdy, s_done, s_key_valid;
    logic [3:0] s_key;
    logic [1:0] s_core_en, s_core_abort, s_core_rdy, s_core_hit;
    logic [7:0] s_core_base, s_core_key;

    crack_scheduler #(.NCORES(2), .KEY_W(4), .CHUNK_LOG2(2)) dut_s (
        .clk(clk), .rst(rst), .en(s_en), .rdy(s_rdy), .done(s_done),
        .key_valid(s_key_valid), .key(s_key), .core_en(s_core_en),
        .core_base(s_core_base), .core_abort(s_core_abort),
        .core_rdy(s_core_rdy), .core_hit(s_core_hit), .core_key(s_core_key)
    );

    // ---------------- default configuration ------------------------------
    logic        b_en, b_rdy, b_done, b_key_valid;
    logic [23:0] b_key;
    logic [1:0]  b_core_en, b_core_abort, b_core_rdy, b_core_hit;
    logic [47:0] b_core_base, b_core_key;

    crack_scheduler dut_b (
        .clk(clk), .rst(rst), .en(b_en), .rdy(b_rdy), .done(b_done),
        .key_valid(b_key_valid), .key(b_key), .core_en(b_core_en),
        .core_base(b_core_base), .core_abort(b_core_abort),
        .core_rdy(b_core_rdy), .core_hit(b_core_hit), .core_key(b_core_key)
    );

    // Behavioural cores: rdy drops the cycle after en, stays low lat cycles,
    // then a one-cycle hit if a planted key lies inside the chunk.
    int         s_lat [2];
    logic       s_run [2];
    int         s_cnt [2];
    logic [3:0] s_cb  [2];
    logic       s_hr  [2];
    logic [3:0] s_kr  [2];
    logic       hk_a_en, hk_b_en;
    logic [3:0] hk_a, hk_b;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                s_run[i] <= 1'b0;
                s_hr[i]  <= 1'b0;
                s_cnt[i] <= 0;
            end else begin
                s_hr[i] <= 1'b0;
                if (s_core_abort[i]) begin
                    s_run[i] <= 1'b0;
                end else if (s_core_en[i]) begin
                    s_run[i] <= 1'b1;
                    s_cnt[i] <= s_lat[i];
                    s_cb[i]  <= s_core_base[i*4 +: 4];
                end else if (s_run[i]) begin
                    s_cnt[i] <= s_cnt[i] - 1;
                    if (s_cnt[i] == 1) begin
                        s_run[i] <= 1'b0;
                        if (hk_a_en && hk_a[3:2] == s_cb[i][3:2]) begin
                            s_hr[i] <= 1'b1;
                            s_kr[i] <= hk_a;
                        end else if (hk_b_en && hk_b[3:2] == s_cb[i][3:2]) begin
                            s_hr[i] <= 1'b1;
                            s_kr[i] <= hk_b;
                        end
                    end
                end
            end
        end
    end

    logic        b_run [2];
    int          b_cnt [2];
    logic [23:0] b_cb  [2];
    logic        b_hr  [2];
    logic [23:0] b_hk;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                b_run[i] <= 1'b0;
                b_hr[i]  <= 1'b0;
                b_cnt[i] <= 0;
            end else begin
                b_hr[i] <= 1'b0;
                if (b_core_abort[i]) begin
                    b_run[i] <= 1'b0;
                end else if (b_core_en[i]) begin
                    b_run[i] <= 1'b1;
                    b_cnt[i] <= 5;
                    b_cb[i]  <= b_core_base[i*24 +: 24];
                end else if (b_run[i]) begin
                    b_cnt[i] <= b_cnt[i] - 1;
                    if (b_cnt[i] == 1) begin
                        b_run[i] <= 1'b0;
                        if (b_hk[23:16] == b_cb[i][23:16]) b_hr[i] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_core
        assign s_core_rdy[g]          = !s_run[g];
        assign s_core_hit[g]          = s_hr[g];
        assign s_core_key[g*4 +: 4]   = s_kr[g];
        assign b_core_rdy[g]          = !b_run[g];
        assign b_core_hit[g]          = b_hr[g];
        assign b_core_key[g*24 +: 24] = b_hk;
    end

    // Dispatch / abort logs, sampled mid-cycle.
    int         log_n = 0;
    int         log_core [64];
    logic [3:0] log_base [64];
    int         ab_cnt [2] = '{0, 0};
    int         b_n = 0;
    logic       b_mono = 1'b1;
    logic [23:0] b_last;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (s_core_en[i]) begin
                    log_core[log_n % 64] = i;
                    log_base[log_n % 64] = s_core_base[i*4 +: 4];
                    log_n++;
                end
                if (s_core_abort[i]) ab_cnt[i]++;
                if (b_core_en[i]) begin
                    if (b_n == 0) b_mono = b_mono && (b_core_base[i*24 +: 24] == 24'h0);
                    else          b_mono = b_mono && (b_core_base[i*24 +: 24] > b_last);
                    b_last = b_core_base[i*24 +: 24];
                    b_n++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic s_start();
        @(negedge clk);
        s_en = 1'b1;
        @(negedge clk);
        s_en = 1'b0;
    endtask

    task automatic wait_s_done(input string tag);
        int t = 0;
        while (!s_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(s_done), 32'd1);
    endtask

    int m, a0, a1, t;

    initial begin
        rst = 1'b1; s_en = 1'b0; b_en = 1'b0;
        hk_a_en = 1'b0; hk_b_en = 1'b0; hk_a = 4'h0; hk_b = 4'h0;
        s_lat[0] = 5; s_lat[1] = 5; b_hk = 24'h1E4600;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_rdy",       32'(s_rdy),        32'd1);
        chk("rst_done",      32'(s_done),       32'd0);
        chk("rst_key_valid", 32'(s_key_valid),  32'd0);
        chk("rst_key",       32'(s_key),        32'd0);
        chk("rst_core_en",   32'(s_core_en),    32'd0);
        chk("rst_abort",     32'(s_core_abort), 32'd0);
        chk("rst_base",      32'(s_core_base),  32'd0);

        // Full sweep, no hit: 0,4 then 8,12 alternating cores
        m = log_n;
        s_start();
        wait_s_done("sweep_done");
        chk("sweep_key_valid", 32'(s_key_valid), 32'd0);
        chk("sweep_rdy",       32'(s_rdy),       32'd1);
        repeat (3) @(negedge clk);
        chk("sweep_en_count", 32'(log_n - m), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_core%0d", k), 32'(log_core[(m+k)%64]), 32'(k % 2));
            chk($sformatf("sweep_base%0d", k), 32'(log_base[(m+k)%64]), 32'(4 * k));
        end

        // Slow core 0 so core 1 picks up chunk 8 and hits key A there
        s_lat[0] = 9; hk_a = 4'hA; hk_a_en = 1'b1;
        m = log_n; a0 = ab_cnt[0]; a1 = ab_cnt[1];
        s_start();
        wait_s_done("hit_done");
        chk("hit_key",       32'(s_key),       32'hA);
        chk("hit_key_valid", 32'(s_key_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("hit_chunk8_core", 32'(log_core[(m+2)%64]), 32'd1);
        chk("hit_chunk8_base", 32'(log_base[(m+2)%64]), 32'd8);
        chk("hit_en_count",    32'(log_n - m),          32'd4);
        chk("hit_abort0",      32'(ab_cnt[0] - a0),     32'd1);
        chk("hit_abort1",      32'(ab_cnt[1] - a1),     32'd0);
        chk("hit_hold_key",    32'(s_key),              32'hA);

        // Restart from DONE
        s_lat[0] = 5; hk_a_en = 1'b0;
        m = log_n;
        s_start();
        chk("restart_done",      32'(s_done),      32'd0);
        chk("restart_key_valid", 32'(s_key_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("restart_base0", 32'(log_base[m%64]), 32'd0);
        chk("restart_core0", 32'(log_core[m%64]), 32'd0);
        wait_s_done("restart_finish");

        // Both cores hit in the same cycle: lowest index wins, nothing aborted
        s_lat[0] = 6; s_lat[1] = 5;
        hk_a = 4'h3; hk_b = 4'h6; hk_a_en = 1'b1; hk_b_en = 1'b1;
        a0 = ab_cnt[0]; a1 = ab_cnt[1];
        s_start();
        wait_s_done("dual_done");
        chk("dual_key",       32'(s_key),       32'h3);
        chk("dual_key_valid", 32'(s_key_valid), 32'd1);
        repeat (2) @(negedge clk);
        chk("dual_abort", 32'((ab_cnt[0] - a0) + (ab_cnt[1] - a1)), 32'd0);

        // Reset in the middle of a search with both cores busy
        s_lat[0] = 5; hk_a_en = 1'b0; hk_b_en = 1'b0;
        s_start();
        repeat (2) @(negedge clk);
        chk("mid_busy_pre", 32'(dut_s.r_busy), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rdy",     32'(s_rdy),        32'd1);
        chk("mid_rst_core_en", 32'(s_core_en),    32'd0);
        chk("mid_rst_done",    32'(s_done),       32'd0);
        chk("mid_rst_busy",    32'(dut_s.r_busy), 32'd0);
        m = log_n;
        s_start();
        repeat (2) @(negedge clk);
        chk("mid_restart_base", 32'(log_base[m%64]), 32'd0);
        chk("mid_restart_n",    32'(log_n - m > 0),   32'd1);
        wait_s_done("mid_restart_finish");

        // Default configuration: single hit at 24'h1E4600 in chunk 0x1E
        @(negedge clk);
        b_en = 1'b1;
        @(negedge clk);
        b_en = 1'b0;
        t = 0;
        while (!b_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("big_done",      32'(b_done),      32'd1);
        chk("big_key",       32'(b_key),       32'h1E4600);
        chk("big_key_valid", 32'(b_key_valid), 32'd1);
        chk("big_en_count",  32'(b_n >= 31 && b_n <= 32), 32'd1);
        chk("big_bases_inc", 32'(b_mono),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crack_scheduler.md
Name: crack_scheduler

Overview:
- Top-level key-space scheduler for the ARC4 key search.
- Splits the 24-bit key space into fixed-size chunks and dispatches them to NCORES parallel crack cores over an en/rdy handshake.
- Collects the first hit, aborts the remaining cores and reports the winning key.
- Sits between the board-level wrapper and the crack core instances, each with its own S/CT/PT memories.

Parameters:
- NCORES, 2, number of crack cores scheduled (1..8).
- KEY_W, 24, key width in bits.
- CHUNK_LOG2, 16, log2 of the keys per dispatched chunk; must satisfy CHUNK_LOG2 <= KEY_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; accepted only in a cycle where rdy=1.
- rdy  out  1  scheduler idle (IDLE or DONE).
- done  out  1  search finished, whether a key was found or the space was exhausted.
- key_valid  out  1  done and a key was found.
- key  out  KEY_W  winning key; valid while key_valid=1.
- core_en  out  NCORES  one-cycle dispatch pulse per core.
- core_base  out  NCORES*KEY_W  chunk base key per core; slice i = [i*KEY_W +: KEY_W]; held until the next dispatch to that core.
- core_abort  out  NCORES  one-cycle stop pulse per core.
- core_rdy  in  NCORES  core idle / finished chunk.
- core_hit  in  NCORES  core found a key; sampled only while that core is busy.
- core_key  in  NCORES*KEY_W  key reported by each core; same slicing as core_base.

Behaviour:
- Reset values: state=IDLE, rdy=1, done=0, key_valid=0, key=0, core_en=0, core_abort=0, core_base=0, busy=0, next_base=0.
- Reset mid-search returns to IDLE immediately; any in-flight core results are ignored.
- Internal registers:
  - next_base, KEY_W+1 bits. Its MSB set means the key space is exhausted.
  - busy[NCORES].
- IDLE: en=1 -> clear done/key_valid, next_base=0, go to RUN.
- RUN, one dispatch per cycle maximum:
  - Select the lowest index i with busy[i]=0 and core_rdy[i]=1, and next_base < 2^KEY_W.
  - On dispatch: core_en[i]=1 for exactly one cycle, core_base[i]=next_base[KEY_W-1:0] (registered the same edge), busy[i]=1, next_base += 2^CHUNK_LOG2.
- Completion:
  - busy[i]=1 and core_rdy[i]=1, excluding the dispatch cycle and the following cycle (2-cycle rdy-drop grace) -> busy[i]=0.
  - The core becomes eligible for dispatch one cycle later.
- Hit:
  - Any busy i with core_hit[i]=1 -> key=core_key[i] of the lowest such index, key_valid=1, done=1.
  - core_abort pulses for one cycle on every other busy core; busy cleared.
  - Go to DONE. A hit takes priority over a completion or dispatch in the same cycle; no dispatch occurs that cycle.
- Exhaustion: next_base MSB set and busy all zero and no hit -> done=1, key_valid=0, go to DONE.
- DONE: rdy=1; done/key/key_valid held. en=1 -> behaves as IDLE start (restart from key 0).
- en while in RUN is ignored.
- core_hit on a non-busy core is ignored.
- Latency: first core_en is 1 cycle after accepting en; done is 1 cycle after the hit/exhaustion cycle.

Test Plan:
- Params KEY_W=4, CHUNK_LOG2=2, NCORES=2; behavioural cores drop rdy 1 cycle after en and finish 5 cycles later. Pulse en; no hits -> bases dispatched in order 0,4 (cores 0,1), then 8,12. done=1, key_valid=0 after the last completion; exactly 4 core_en pulses total.
- Same setup; core 1 asserts hit with core_key=4'hA during chunk 8 -> key=4'hA, key_valid=1, core_abort[0] pulses once, no further core_en.
- Both cores hit in the same cycle with keys 4'h3 and 4'h6 -> key=4'h3 (lowest index wins); core_abort=0.
- Assert rst during RUN with both cores busy -> next cycle rdy=1, core_en=0, busy cleared. Subsequent en restarts with core_base=0.
- From DONE (key 4'hA found), pulse en -> done and key_valid drop the next cycle; redispatch starts at base 0.
- Defaults (KEY_W=24, CHUNK_LOG2=16, NCORES=2); a single core hits key 24'h1E4600 in chunk 0x1E -> done with key=24'h1E4600. A total of 0x1F core_en pulses is acceptable if bases are strictly increasing.
